crc_stream: RTL and testbench

- Parametrised, framed serial/parallel CRC engine.
- Generalises the bit-serial crc8 block to any CRC width, polynomial, init/xor-out value, bit order and beats of 1..N bits per clock.
- Adds valid/ready input and output handshakes, frame start/last control, and a bit counter.
- Sits between a bit/byte producer and frame-check logic.

---
 rtl/crc_stream_pkg.sv | 13 +
 rtl/crc_stream_crc_update.sv | 35 +++
 rtl/crc_stream.sv | 128 ++++++++++++
 tb/tb_crc_stream.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/crc_stream_pkg.sv
// Shared types and polynomial constants for the crc_stream engine.
package crc_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0]  POLY_CRC8        = 8'h07;
  localparam logic [15:0] POLY_CRC16_CCITT = 16'h1021;

endpackage

// File: rtl/crc_stream_crc_update.sv
// Combinational CRC step: folds DATA_W bits into crc_in in one cycle.
module crc_update #(
  parameter int              CRC_W     = 8,
  parameter logic [CRC_W-1:0] POLY     = 'h07,
  parameter int              DATA_W    = 1,
  parameter bit              LSB_FIRST = 1'b1
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_next
);

  // Reorder so processing order is always ord[0], ord[1], ...
  logic [DATA_W-1:0] ord;
  for (genvar g = 0; g < DATA_W; g++) begin : g_ord
    assign ord[g] = LSB_FIRST ? data[g] : data[DATA_W-1-g];
  end

  logic [CRC_W-1:0]  c;
  logic [DATA_W-1:0] sh;
  logic              fb;

  always_comb begin
    c  = crc_in;
    sh = ord;
    fb = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      fb = c[CRC_W-1] ^ sh[0];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      sh = sh >> 1;
    end
    crc_next = c;
  end

endmodule

// File: rtl/crc_stream.sv
// Framed CRC engine with valid/ready handshakes and a saturating bit counter.
// Optional CRC_STREAM_CHECK_EN adds exp_crc input and registered crc_match.
module crc_stream
  import crc_stream_pkg::*;
#(
  parameter int               CRC_W     = 8,
  parameter logic [CRC_W-1:0] POLY      = 'h07,
  parameter logic [CRC_W-1:0] INIT      = '0,
  parameter logic [CRC_W-1:0] XOR_OUT   = '0,
  parameter int               DATA_W    = 1,
  parameter bit               LSB_FIRST = 1'b1,
  parameter int               CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic [CNT_W-1:0]  bit_count,
`ifdef CRC_STREAM_CHECK_EN
  input  logic [CRC_W-1:0]  exp_crc,
  output logic              crc_match,
`endif
  output logic              busy
);

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d, crc_next;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W:0]     cnt_sum;

  crc_update #(
    .CRC_W(CRC_W), .POLY(POLY), .DATA_W(DATA_W), .LSB_FIRST(LSB_FIRST)
  ) u_update (
    .crc_in(crc_q), .data(in_data), .crc_next(crc_next)
  );

  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(DATA_W);

`ifdef CRC_STREAM_CHECK_EN
  logic match_q, match_d;
  assign crc_match = match_q;
`endif

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
`ifdef CRC_STREAM_CHECK_EN
    match_d = match_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          crc_d   = INIT;
          cnt_d   = '0;
`ifdef CRC_STREAM_CHECK_EN
          match_d = 1'b0;
`endif
        end
      end
      RUN: begin
        // Restart wins over any beat presented in the same cycle.
        if (start) begin
          crc_d = INIT;
          cnt_d = '0;
`ifdef CRC_STREAM_CHECK_EN
          match_d = 1'b0;
`endif
        end else if (in_valid) begin
          crc_d = crc_next;
          cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
          if (in_last) begin
            state_d = DONE;
`ifdef CRC_STREAM_CHECK_EN
            match_d = ((crc_next ^ XOR_OUT) == exp_crc);
`endif
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (start) begin
            state_d = RUN;
            crc_d   = INIT;
            cnt_d   = '0;
`ifdef CRC_STREAM_CHECK_EN
            match_d = 1'b0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      cnt_q   <= '0;
`ifdef CRC_STREAM_CHECK_EN
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
`ifdef CRC_STREAM_CHECK_EN
      match_q <= match_d;
`endif
    end
  end

  assign in_ready  = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign crc_out   = crc_q ^ XOR_OUT;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench: bit-serial CRC-8, byte-wide CRC-8 and two CRC-16 variants.
module tb_crc_stream;
  import crc_stream_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // bit-serial instance
  logic        s_start = 0, s_valid = 0, s_last = 0, s_oready = 0;
  logic [0:0]  s_data = '0;
  logic        s_ready, s_ovalid, s_busy;
  logic [7:0]  s_crc;
  logic [15:0] s_cnt;

  // byte-wide instances share stimulus
  logic        p_start = 0, p_valid = 0, p_last = 0, p_oready = 0;
  logic [7:0]  p_data = '0;
  logic [7:0]  p_exp8 = '0;
  logic        a_ready, a_ovalid, a_busy;
  logic        b_ready, b_ovalid, b_busy;
  logic        c_ready, c_ovalid, c_busy;
  logic [7:0]  a_crc;
  logic [15:0] b_crc, c_crc;
  logic [15:0] a_cnt, b_cnt, c_cnt;
`ifdef CRC_STREAM_CHECK_EN
  logic s_match, a_match, b_match, c_match;
`endif

  crc_stream #(.CRC_W(8), .POLY(POLY_CRC8), .INIT(8'h00), .XOR_OUT(8'h00),
               .DATA_W(1), .LSB_FIRST(1'b1), .CNT_W(16)) u_s (
`ifdef CRC_STREAM_CHECK_EN
    .exp_crc(8'h00), .crc_match(s_match),
`endif
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_data(s_data), .in_last(s_last), .out_valid(s_ovalid), .out_ready(s_oready),
    .crc_out(s_crc), .bit_count(s_cnt), .busy(s_busy));

  crc_stream #(.CRC_W(8), .POLY(POLY_CRC8), .INIT(8'h00), .XOR_OUT(8'h00),
               .DATA_W(8), .LSB_FIRST(1'b0), .CNT_W(16)) u_a (
`ifdef CRC_STREAM_CHECK_EN
    .exp_crc(p_exp8), .crc_match(a_match),
`endif
    .clk(clk), .rst(rst), .start(p_start), .in_valid(p_valid), .in_ready(a_ready),
    .in_data(p_data), .in_last(p_last), .out_valid(a_ovalid), .out_ready(p_oready),
    .crc_out(a_crc), .bit_count(a_cnt), .busy(a_busy));

  crc_stream #(.CRC_W(16), .POLY(POLY_CRC16_CCITT), .INIT(16'hFFFF), .XOR_OUT(16'h0000),
               .DATA_W(8), .LSB_FIRST(1'b0), .CNT_W(16)) u_b (
`ifdef CRC_STREAM_CHECK_EN
    .exp_crc(16'h0000), .crc_match(b_match),
`endif
    .clk(clk), .rst(rst), .start(p_start), .in_valid(p_valid), .in_ready(b_ready),
    .in_data(p_data), .in_last(p_last), .out_valid(b_ovalid), .out_ready(p_oready),
    .crc_out(b_crc), .bit_count(b_cnt), .busy(b_busy));

  crc_stream #(.CRC_W(16), .POLY(POLY_CRC16_CCITT), .INIT(16'h0000), .XOR_OUT(16'h0000),
               .DATA_W(8), .LSB_FIRST(1'b0), .CNT_W(16)) u_c (
`ifdef CRC_STREAM_CHECK_EN
    .exp_crc(16'h0000), .crc_match(c_match),
`endif
    .clk(clk), .rst(rst), .start(p_start), .in_valid(p_valid), .in_ready(c_ready),
    .in_data(p_data), .in_last(p_last), .out_valid(c_ovalid), .out_ready(p_oready),
    .crc_out(c_crc), .bit_count(c_cnt), .busy(c_busy));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    p_valid = 1'b1;
    p_data  = b;
    p_last  = last;
    tick();
    p_valid = 1'b0;
    p_last  = 1'b0;
  endtask

  // Reference MSB-first CRC-8 (poly 07, init 0) over the first n chars of s.
  function automatic logic [7:0] crc8_ref(input string s, input int n);
    logic [7:0] c;
    logic [7:0] ch;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      ch = s[i];
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ ch[k];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  initial begin
    string      msg;
    logic [7:0] bv;
    msg = "123456789";
    bv  = 8'h2D;

    // reset state
    repeat (2) tick();
    chk("rst_s_ready",  s_ready,  1'b0);
    chk("rst_s_ovalid", s_ovalid, 1'b0);
    chk("rst_s_busy",   s_busy,   1'b0);
    chk("rst_s_crc",    s_crc,    8'h00);
    chk("rst_s_cnt",    s_cnt,    16'd0);
    chk("rst_b_crc",    b_crc,    16'hFFFF);
    chk("rst_a_ready",  a_ready,  1'b0);
    rst = 1'b0;

    // bit-serial 0x2D, LSB first
    s_start = 1'b1; tick(); s_start = 1'b0;
    chk("s_busy_run",  s_busy,  1'b1);
    chk("s_ready_run", s_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = bv[i]; s_last = (i == 7); tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("s_ovalid", s_ovalid, 1'b1);
    chk("s_crc",    s_crc,    8'h05);
    chk("s_cnt",    s_cnt,    16'd8);
    chk("s_ready_done", s_ready, 1'b0);
    s_oready = 1'b1; tick(); s_oready = 1'b0;
    chk("s_ovalid_idle", s_ovalid, 1'b0);
    chk("s_busy_idle",   s_busy,   1'b0);
    chk("s_crc_hold",    s_crc,    8'h05);

    // reset mid-frame, beat still offered
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 1'b1; tick();
    end
    rst = 1'b1; tick(); rst = 1'b0; s_valid = 1'b0;
    chk("abort_rst_crc",    s_crc,    8'h00);
    chk("abort_rst_cnt",    s_cnt,    16'd0);
    chk("abort_rst_ready",  s_ready,  1'b0);
    chk("abort_rst_busy",   s_busy,   1'b0);
    chk("abort_rst_ovalid", s_ovalid, 1'b0);

    // byte-wide single beat 0x2D
    p_start = 1'b1; tick(); p_start = 1'b0;
    send(8'h2D, 1'b1);
    chk("p1_ovalid", a_ovalid, 1'b1);
    chk("p1_crc",    a_crc,    8'hC3);
    chk("p1_cnt",    a_cnt,    16'd8);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("p1_hold_ovalid", a_ovalid, 1'b1);
      chk("p1_hold_crc",    a_crc,    8'hC3);
    end
    p_start = 1'b1; tick(); p_start = 1'b0;
    chk("done_start_ign_ovalid", a_ovalid, 1'b1);
    chk("done_start_ign_crc",    a_crc,    8'hC3);

    // back-to-back: out_ready with start
    p_oready = 1'b1; p_start = 1'b1; tick(); p_oready = 1'b0; p_start = 1'b0;
    chk("b2b_ovalid", a_ovalid, 1'b0);
    chk("b2b_ready",  a_ready,  1'b1);
    chk("b2b_crc",    a_crc,    8'h00);
    chk("b2b_cnt",    a_cnt,    16'd0);
    chk("b2b_b_crc",  b_crc,    16'hFFFF);

    // "123456789" with a 3-cycle stall after 4 bytes
    p_exp8 = 8'hF4;
    for (int i = 0; i < 4; i++) send(msg[i], 1'b0);
    chk("mid_cnt", a_cnt, 16'd32);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_crc", a_crc, crc8_ref(msg, 4));
      chk("stall_cnt", a_cnt, 16'd32);
    end
    for (int i = 4; i < 9; i++) send(msg[i], i == 8);
    chk("chk8_crc",    a_crc, 8'hF4);
    chk("ccitt_crc",   b_crc, 16'h29B1);
    chk("xmodem_crc",  c_crc, 16'h31C3);
    chk("chk8_cnt",    a_cnt, 16'd72);
    chk("ccitt_cnt",   b_cnt, 16'd72);
    chk("ccitt_valid", b_ovalid, 1'b1);
`ifdef CRC_STREAM_CHECK_EN
    chk("match_good", a_match, 1'b1);
`endif

    // next frame back-to-back, 0x2D again
    p_oready = 1'b1; p_start = 1'b1; tick(); p_oready = 1'b0; p_start = 1'b0;
    chk("b2b2_busy", a_busy, 1'b1);
`ifdef CRC_STREAM_CHECK_EN
    chk("match_clr_start", a_match, 1'b0);
`endif
    p_exp8 = 8'hC3;
    send(8'h2D, 1'b1);
    chk("p2_crc",    a_crc,    8'hC3);
    chk("p2_ovalid", a_ovalid, 1'b1);
`ifdef CRC_STREAM_CHECK_EN
    chk("match_p2", a_match, 1'b1);
`endif
    p_oready = 1'b1; tick(); p_oready = 1'b0;
    chk("p2_idle_busy", a_busy, 1'b0);
    chk("p2_idle_crc",  a_crc,  8'hC3);
    chk("p2_idle_cnt",  a_cnt,  16'd8);

    // start in RUN after 4 beats, with a beat offered at the same time
    p_start = 1'b1; tick(); p_start = 1'b0;
    for (int i = 0; i < 4; i++) send(msg[i], 1'b0);
    p_start = 1'b1; p_valid = 1'b1; p_data = msg[4]; tick();
    p_start = 1'b0; p_valid = 1'b0;
    chk("restart_cnt",   a_cnt,   16'd0);
    chk("restart_crc",   a_crc,   8'h00);
    chk("restart_b_crc", b_crc,   16'hFFFF);
    chk("restart_busy",  a_busy,  1'b1);
    chk("restart_ready", a_ready, 1'b1);

    p_exp8 = 8'hF5;
    for (int i = 0; i < 9; i++) send(msg[i], i == 8);
    chk("p3_crc",   a_crc, 8'hF4);
    chk("p3_cnt",   a_cnt, 16'd72);
    chk("p3_b_crc", b_crc, 16'h29B1);
`ifdef CRC_STREAM_CHECK_EN
    chk("match_bad", a_match, 1'b0);
`endif
    p_oready = 1'b1; tick(); p_oready = 1'b0;
    chk("p3_ovalid_idle", a_ovalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
